key_event_unit: RTL and testbench

Parametrised multi-key front end for the board test controllers (QSPI flash tester and successors). It replaces ad-hoc per-button edge logic with a uniform block providing:
- synchronisation and debounce of N raw buttons;
- per-key press/release pulses;
- a single valid/ready event stream that a controller FSM consumes one event at a time.

Optional auto-repeat produces repeated press events while a key is held.

---
 rtl/key_event_unit.sv | 187 ++++++++++++++++++
 tb/tb_key_event_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_unit.sv
// key_event_unit: multi-key front end for the board test controllers.
// The block synchronises and debounces N raw buttons. It produces per-key
// press/release pulses and presents one valid/ready event stream that is
// consumed one event at a time.
// Optional auto-repeat of held keys is compiled in when the macro
// KEY_REPEAT_EN is defined. The default build has no repeat logic.
module key_event_unit #(
    parameter int N_KEYS         = 5,
    parameter int DEB_CYCLES     = 16,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100,
    localparam int IDXW          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] level_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [IDXW+1:0]   ev_code,
    output logic              ovf_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [N_KEYS-1:0] IDLE_PIN = KEY_ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    logic [N_KEYS-1:0] sync1, sync2, sample;
    logic [CW-1:0]     deb_cnt [N_KEYS];
    logic [N_KEYS-1:0] press_set, release_set, repeat_set;
    logic [N_KEYS-1:0] pend_p, pend_r, pend_rep;
    logic [N_KEYS-1:0] sel_p, sel_r, sel_rep;
    logic [N_KEYS-1:0] clr_p, clr_r, clr_rep;
    logic [N_KEYS-1:0] lost;
    logic              take;
    logic              found;

    // Two-flop synchroniser, then a registered pressed=1 sample that feeds the debouncer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= IDLE_PIN;
            sync2  <= IDLE_PIN;
            sample <= '0;
        end else begin
            sync1  <= keys;
            sync2  <= sync1;
            sample <= KEY_ACTIVE_LOW ? ~sync2 : sync2;
        end
    end

    // A level change is accepted on the edge where the run of differing samples reaches DEB_CYCLES
    always_comb begin
        press_set   = '0;
        release_set = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if ((sample[i] != level_o[i]) && (deb_cnt[i] == DEB_LAST)) begin
                press_set[i]   = sample[i];
                release_set[i] = ~sample[i];
            end
        end
    end

    // Per-key debounce counter and debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_o <= '0;
            for (int i = 0; i < N_KEYS; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (sample[i] == level_o[i]) begin
                    deb_cnt[i] <= '0;
                end else if (press_set[i] || release_set[i]) begin
                    deb_cnt[i] <= '0;
                    level_o[i] <= ~level_o[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    logic [RCW-1:0]    rep_cnt [N_KEYS];
    logic [N_KEYS-1:0] rep_first;

    // A held key repeats after the initial delay, then once per period
    always_comb begin
        repeat_set = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (level_o[i] && !release_set[i]) begin
                if ((rep_first[i] && (rep_cnt[i] == DELAY_LAST)) ||
                    (!rep_first[i] && (rep_cnt[i] == PERIOD_LAST))) begin
                    repeat_set[i] = 1'b1;
                end
            end
        end
    end

    // Repeat timers run only while the debounced level is pressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_first <= '1;
            for (int i = 0; i < N_KEYS; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!level_o[i] || release_set[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (repeat_set[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign repeat_set = '0;
`endif

    // Registered one-cycle pulses; a repeat also shows up as a press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_o   <= '0;
            release_o <= '0;
        end else begin
            press_o   <= press_set | repeat_set;
            release_o <= release_set;
        end
    end

    // Pick the lowest key with anything pending; inside a key, press beats repeat beats release
    always_comb begin
        sel_p   = '0;
        sel_r   = '0;
        sel_rep = '0;
        ev_code = '0;
        found   = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (!found && (pend_p[i] || pend_r[i] || pend_rep[i])) begin
                found = 1'b1;
                if (pend_p[i]) begin
                    sel_p[i] = 1'b1;
                    ev_code  = {2'b00, IDXW'(i)};
                end else if (pend_rep[i]) begin
                    sel_rep[i] = 1'b1;
                    ev_code    = {2'b10, IDXW'(i)};
                end else begin
                    sel_r[i] = 1'b1;
                    ev_code  = {2'b01, IDXW'(i)};
                end
            end
        end
    end

    assign ev_valid = |{pend_p, pend_r, pend_rep};
    assign take     = ev_valid && ev_ready;
    assign clr_p    = sel_p & {N_KEYS{take}};
    assign clr_r    = sel_r & {N_KEYS{take}};
    assign clr_rep  = sel_rep & {N_KEYS{take}};
    assign lost     = (press_set & pend_p & ~clr_p) |
                      (release_set & pend_r & ~clr_r) |
                      (repeat_set & pend_rep & ~clr_rep);

    // Pending bits: a set wins over a same-edge clear; setting an uncleared bit loses an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p   <= '0;
            pend_r   <= '0;
            pend_rep <= '0;
            ovf_o    <= 1'b0;
        end else begin
            pend_p   <= (pend_p & ~clr_p) | press_set;
            pend_r   <= (pend_r & ~clr_r) | release_set;
            pend_rep <= (pend_rep & ~clr_rep) | repeat_set;
            if (|lost) ovf_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_key_event_unit.sv
// tb_key_event_unit: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a behavioural model built from key-hold history.
module tb_key_event_unit;
    localparam int N    = 5;
    localparam int DEB  = 16;
    localparam int RD   = 50;
    localparam int RP   = 20;
    localparam int IDXW = 3;
    localparam int CW   = IDXW + 2;
    localparam int HL   = DEB + 3;
`ifdef KEY_REPEAT_EN
    localparam int EXP_REPEATS = 8;
`else
    localparam int EXP_REPEATS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  keys;
    logic [N-1:0]  level_o, press_o, release_o;
    logic          ev_valid, ev_ready, ovf_o;
    logic [CW-1:0] ev_code;

    int checks = 0;
    int errors = 0;
    int pulse_count = 0;
    logic [CW-1:0] hs_log[$];

    bit m_level[N], m_press[N], m_rel[N];
    bit p_p[N], p_r[N], p_rep[N];
    bit m_ovf;
    int m_press_t[N];
    int cyc = 0;
    bit hist[N][HL];

    key_event_unit #(
        .N_KEYS(N), .DEB_CYCLES(DEB), .KEY_ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [CW-1:0] mkCode(input logic [1:0] typ, input int key);
        return {typ, IDXW'(key)};
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < N; k++) begin
            m_level[k] = 0; m_press[k] = 0; m_rel[k] = 0;
            p_p[k] = 0; p_r[k] = 0; p_rep[k] = 0;
            m_press_t[k] = 0;
            for (int j = 0; j < HL; j++) hist[k][j] = 0;
        end
        m_ovf = 0;
    endfunction

    // Expected head event: lowest key wins, so scan downward and let lower keys overwrite
    function automatic void arbitrate(output bit v, output logic [CW-1:0] c);
        v = 0;
        c = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (p_p[k] || p_r[k] || p_rep[k]) begin
                v = 1;
                if (p_p[k])        c = mkCode(2'b00, k);
                else if (p_rep[k]) c = mkCode(2'b10, k);
                else               c = mkCode(2'b01, k);
            end
        end
    endfunction

    // One rising edge of the reference: a level flips once the last DEB pin samples,
    // seen three edges late through the input pipeline, all disagree with it
    task automatic modelEdge(input logic [N-1:0] pins, input logic rdy, input logic rstn);
        bit v;
        logic [CW-1:0] c;
        bit all_diff;
        int k_sel;
        bit set_p[N], set_r[N], set_rep[N], clr_p[N], clr_r[N], clr_rep[N];
        cyc++;
        if (!rstn) begin
            modelReset();
            return;
        end
        arbitrate(v, c);
        for (int k = 0; k < N; k++) begin
            set_p[k] = 0; set_r[k] = 0; set_rep[k] = 0;
            clr_p[k] = 0; clr_r[k] = 0; clr_rep[k] = 0;
        end
        if (v && rdy) begin
            k_sel = int'(c[IDXW-1:0]);
            case (c[CW-1:IDXW])
                2'b00:   clr_p[k_sel] = 1;
                2'b01:   clr_r[k_sel] = 1;
                default: clr_rep[k_sel] = 1;
            endcase
        end
        for (int k = 0; k < N; k++) begin
            for (int j = HL - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = ~pins[k];
            all_diff = 1;
            for (int j = 3; j < HL; j++) if (hist[k][j] == m_level[k]) all_diff = 0;
            m_press[k] = 0;
            m_rel[k] = 0;
            if (all_diff) begin
                m_level[k] = ~m_level[k];
                if (m_level[k]) begin
                    m_press[k] = 1; set_p[k] = 1; m_press_t[k] = cyc;
                end else begin
                    m_rel[k] = 1; set_r[k] = 1;
                end
            end
`ifdef KEY_REPEAT_EN
            else if (m_level[k] && (cyc - m_press_t[k]) >= RD && ((cyc - m_press_t[k] - RD) % RP) == 0) begin
                m_press[k] = 1; set_rep[k] = 1;
            end
`endif
            if (set_p[k] && p_p[k] && !clr_p[k]) m_ovf = 1;
            if (set_r[k] && p_r[k] && !clr_r[k]) m_ovf = 1;
            if (set_rep[k] && p_rep[k] && !clr_rep[k]) m_ovf = 1;
            p_p[k]   = (p_p[k] && !clr_p[k]) || set_p[k];
            p_r[k]   = (p_r[k] && !clr_r[k]) || set_r[k];
            p_rep[k] = (p_rep[k] && !clr_rep[k]) || set_rep[k];
        end
    endtask

    task automatic compareAll();
        logic [N-1:0] e_level, e_press, e_rel;
        bit v;
        logic [CW-1:0] c;
        for (int k = 0; k < N; k++) begin
            e_level[k] = m_level[k];
            e_press[k] = m_press[k];
            e_rel[k]   = m_rel[k];
        end
        arbitrate(v, c);
        checkOutput("level_o", 32'(level_o), 32'(e_level));
        checkOutput("press_o", 32'(press_o), 32'(e_press));
        checkOutput("release_o", 32'(release_o), 32'(e_rel));
        checkOutput("ev_valid", 32'(ev_valid), 32'(v));
        if (v) checkOutput("ev_code", 32'(ev_code), 32'(c));
        checkOutput("ovf_o", 32'(ovf_o), 32'(m_ovf));
    endtask

    // Advance n clock edges with the currently driven inputs, logging handshakes
    task automatic applyStimulus(input int n);
        for (int s = 0; s < n; s++) begin
            if (rst_n && ev_valid && ev_ready) hs_log.push_back(ev_code);
            @(posedge clk);
            modelEdge(keys, ev_ready, rst_n);
            #1;
            compareAll();
            pulse_count += $countones({press_o, release_o});
        end
    endtask

    task automatic measureLatency(input int key, input bit want_press, output int lat);
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(1);
            if (want_press ? press_o[key] : release_o[key]) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic int countCode(input int base, input logic [CW-1:0] code);
        int n = 0;
        for (int i = base; i < hs_log.size(); i++) if (hs_log[i] == code) n++;
        return n;
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int base;
        int pbase;
        rst_n = 1'b0;
        keys = '1;
        ev_ready = 1'b0;
        modelReset();
        $display("[TB] reset");
        applyStimulus(5);
        checkOutput("rst_level", 32'(level_o), 32'd0);
        checkOutput("rst_valid", 32'(ev_valid), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_o), 32'd0);
        rst_n = 1'b1;
        pbase = pulse_count;
        applyStimulus(100);
        checkOutput("idle_pulses", 32'(pulse_count - pbase), 32'd0);

        $display("[TB] glitch and latency");
        pbase = pulse_count;
        keys[0] = 1'b0;
        applyStimulus(DEB - 1);
        keys[0] = 1'b1;
        applyStimulus(30);
        checkOutput("glitch_pulses", 32'(pulse_count - pbase), 32'd0);
        checkOutput("glitch_valid", 32'(ev_valid), 32'd0);
        keys[0] = 1'b0;
        measureLatency(0, 1'b1, lat);
        checkOutput("press_lat", 32'(lat), 32'd18);
        checkOutput("press_code", 32'(ev_code), 32'(mkCode(2'b00, 0)));
        applyStimulus(21);
        keys[0] = 1'b1;
        measureLatency(0, 1'b0, lat);
        checkOutput("release_lat", 32'(lat), 32'd18);
        ev_ready = 1'b1;
        applyStimulus(3);
        ev_ready = 1'b0;

        $display("[TB] arbitration");
        keys[4] = 1'b0;
        keys[1] = 1'b0;
        applyStimulus(25);
        checkOutput("arb_first", 32'(ev_code), 32'(mkCode(2'b00, 1)));
        ev_ready = 1'b1;
        applyStimulus(1);
        ev_ready = 1'b0;
        checkOutput("arb_second", 32'(ev_code), 32'(mkCode(2'b00, 4)));
        ev_ready = 1'b1;
        applyStimulus(1);
        ev_ready = 1'b0;
        checkOutput("arb_empty", 32'(ev_valid), 32'd0);
        keys[1] = 1'b1;
        keys[4] = 1'b1;
        ev_ready = 1'b1;
        applyStimulus(25);
        ev_ready = 1'b0;

        $display("[TB] set and clear on the same edge");
        keys[2] = 1'b0;
        applyStimulus(20);
        keys[2] = 1'b1;
        applyStimulus(20);
        keys[2] = 1'b0;
        applyStimulus(DEB + 2);
        ev_ready = 1'b1;
        applyStimulus(1);
        ev_ready = 1'b0;
        checkOutput("coinc_valid", 32'(ev_valid), 32'd1);
        checkOutput("coinc_code", 32'(ev_code), 32'(mkCode(2'b00, 2)));
        checkOutput("coinc_ovf", 32'(ovf_o), 32'd0);
        ev_ready = 1'b1;
        applyStimulus(3);
        keys[2] = 1'b1;
        applyStimulus(22);
        ev_ready = 1'b0;
        checkOutput("coinc_ovf_after", 32'(ovf_o), 32'd0);

        $display("[TB] overflow");
        base = hs_log.size();
        keys[2] = 1'b0;
        applyStimulus(20);
        keys[2] = 1'b1;
        applyStimulus(20);
        keys[2] = 1'b0;
        applyStimulus(20);
        checkOutput("ovf_set", 32'(ovf_o), 32'd1);
        ev_ready = 1'b1;
        applyStimulus(4);
        ev_ready = 1'b0;
        checkOutput("ovf_events", 32'(hs_log.size() - base), 32'd2);
        checkOutput("ovf_ev0", 32'(hs_log[base]), 32'(mkCode(2'b00, 2)));
        checkOutput("ovf_ev1", 32'(hs_log[base+1]), 32'(mkCode(2'b01, 2)));
        keys[2] = 1'b1;
        applyStimulus(20);
        ev_ready = 1'b1;
        applyStimulus(2);
        checkOutput("ovf_sticky", 32'(ovf_o), 32'd1);
        ev_ready = 1'b0;

        $display("[TB] reset mid-operation");
        keys[3] = 1'b0;
        keys[0] = 1'b0;
        applyStimulus(20);
        keys[1] = 1'b0;
        applyStimulus(13);
        rst_n = 1'b0;
        keys = '1;
        applyStimulus(3);
        checkOutput("mid_rst_valid", 32'(ev_valid), 32'd0);
        checkOutput("mid_rst_ovf", 32'(ovf_o), 32'd0);
        checkOutput("mid_rst_level", 32'(level_o), 32'd0);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        base = hs_log.size();
        pbase = pulse_count;
        applyStimulus(100);
        checkOutput("mid_rst_events", 32'(hs_log.size() - base), 32'd0);
        checkOutput("mid_rst_pulses", 32'(pulse_count - pbase), 32'd0);

        $display("[TB] hold key3");
        base = hs_log.size();
        keys[3] = 1'b0;
        measureLatency(3, 1'b1, lat);
        checkOutput("hold_press_lat", 32'(lat), 32'd18);
        applyStimulus(181);
        keys[3] = 1'b1;
        applyStimulus(40);
        checkOutput("hold_press_cnt", 32'(countCode(base, mkCode(2'b00, 3))), 32'd1);
        checkOutput("hold_repeat_cnt", 32'(countCode(base, mkCode(2'b10, 3))), 32'(EXP_REPEATS));
        checkOutput("hold_release_cnt", 32'(countCode(base, mkCode(2'b01, 3))), 32'd1);

        $display("[TB] randomized phase");
        for (int r = 0; r < 1500; r++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 29) == 0) keys[k] = ~keys[k];
            ev_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(1);
        end
        keys = '1;
        ev_ready = 1'b1;
        applyStimulus(60);
        checkOutput("final_valid", 32'(ev_valid), 32'd0);
        checkOutput("final_level", 32'(level_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
